// File: rtl/expr_eval.sv
// Evaluates an ASCII stream of single-digit operands with '+' and '*' ('*' binds tighter),
// terminated by '='. Reports the result or a syntax error with a one-cycle done pulse.
module expr_eval #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  typedef enum logic [1:0] {START, OP, NUM, ERR} state_t;

  state_t       state, state_nx;
  logic [W-1:0] sum, sum_nx;
  logic [W-1:0] prod, prod_nx;
  logic [W-1:0] result_nx;
  logic         err_nx, done_nx;
  logic         fin_good, fin_err;

  logic         is_digit, is_plus, is_mul, is_eq;
  logic [W-1:0] digit;

  assign is_digit = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus  = (in == 8'h2b);
  assign is_mul   = (in == 8'h2a);
  assign is_eq    = (in == 8'h3d);
  assign digit    = W'(in[3:0]);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state  <= START;
      sum    <= '0;
      prod   <= W'(1);
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      sum    <= sum_nx;
      prod   <= prod_nx;
      done   <= done_nx;
      result <= result_nx;
      err    <= err_nx;
    end
  end

  // Next state and accumulators; a finish returns to START with fresh sum/prod.
  always_comb begin
    state_nx = state;
    sum_nx   = sum;
    prod_nx  = prod;
    fin_good = 1'b0;
    fin_err  = 1'b0;
    if (in_valid) begin
      unique case (state)
        START, OP: begin
          if (is_digit) begin
            prod_nx  = prod * digit;
            state_nx = NUM;
          end else if (is_eq) begin
            fin_err = 1'b1;
          end else begin
            state_nx = ERR;
          end
        end
        NUM: begin
          if (is_plus) begin
            sum_nx   = sum + prod;
            prod_nx  = W'(1);
            state_nx = OP;
          end else if (is_mul) begin
            state_nx = OP;
          end else if (is_eq) begin
            fin_good = 1'b1;
          end else begin
            state_nx = ERR;
          end
        end
        ERR: begin
          if (is_eq) fin_err = 1'b1;
        end
        default: state_nx = ERR;
      endcase
      if (fin_good || fin_err) begin
        sum_nx   = '0;
        prod_nx  = W'(1);
        state_nx = START;
      end
    end
  end

  always_comb begin
    done_nx   = fin_good | fin_err;
    result_nx = result;
    err_nx    = err;
    if (fin_good) begin
      result_nx = sum + prod;
      err_nx    = 1'b0;
    end else if (fin_err) begin
      result_nx = '0;
      err_nx    = 1'b1;
    end
  end

endmodule
